// File: rtl/exc_sequencer_pkg.sv
// Shared definitions for the exception sequencer: ExcCode values, the default
// exception entry vector, the drain watchdog default and the FSM state type.
package exc_sequencer_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ERET = 5'h11;

  localparam logic [31:0] EXC_VECTOR_DEFAULT    = 32'hbfc00380;
  localparam int          DRAIN_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_REDIRECT = 2'd3
  } seq_state_t;

  // A way carries an event only when its code is something other than "none".
  function automatic logic is_event_code(input logic [4:0] code);
    return code != EXC_NONE;
  endfunction

endpackage

// File: rtl/exc_way_prio.sv
// Combinational event picker for the two EX-stage ways.
// Priority: pending interrupt > way0 exception > way1 exception. An interrupt
// rides on the oldest valid way; with no valid way it simply waits.
module exc_way_prio
  import exc_sequencer_pkg::*;
(
  input  logic        int_pending,
  input  logic [1:0]  ex_valid,
  input  logic [9:0]  ex_exc_code,
  input  logic [63:0] ex_pc,
  input  logic [1:0]  ex_in_delay,
  output logic        sel_valid,
  output logic        sel_way,
  output logic [4:0]  sel_code,
  output logic [31:0] sel_pc,
  output logic        sel_bd
);

  logic way0_hit;
  logic way1_hit;

  assign way0_hit = ex_valid[0] && is_event_code(ex_exc_code[4:0]);
  assign way1_hit = ex_valid[1] && is_event_code(ex_exc_code[9:5]);

  // Pick the highest-priority event and carry along its PC and delay-slot flag.
  always_comb begin
    sel_valid = 1'b0;
    sel_way   = 1'b0;
    sel_code  = EXC_NONE;
    sel_pc    = 32'h0;
    sel_bd    = 1'b0;
    if (int_pending && ex_valid[0]) begin
      sel_valid = 1'b1;
      sel_way   = 1'b0;
      sel_code  = EXC_INT;
      sel_pc    = ex_pc[31:0];
      sel_bd    = ex_in_delay[0];
    end else if (int_pending && ex_valid[1]) begin
      sel_valid = 1'b1;
      sel_way   = 1'b1;
      sel_code  = EXC_INT;
      sel_pc    = ex_pc[63:32];
      sel_bd    = ex_in_delay[1];
    end else if (way0_hit) begin
      sel_valid = 1'b1;
      sel_way   = 1'b0;
      sel_code  = ex_exc_code[4:0];
      sel_pc    = ex_pc[31:0];
      sel_bd    = ex_in_delay[0];
    end else if (way1_hit) begin
      sel_valid = 1'b1;
      sel_way   = 1'b1;
      sel_code  = ex_exc_code[9:5];
      sel_pc    = ex_pc[63:32];
      sel_bd    = ex_in_delay[1];
    end
  end

endmodule

// File: rtl/exc_sequencer.sv
// Exception / interrupt / ERET sequencer in front of CP0.
// IDLE -> COMMIT -> DRAIN -> REDIRECT -> IDLE: latch one event, strobe CP0 once,
// wait for the pipeline to drain, then hand the redirect PC to IF.
// Optional drain watchdog: define EXC_SEQ_DRAIN_TIMEOUT_EN.
module exc_sequencer
  import exc_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEFAULT,
  parameter int          DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_pending,
  input  logic [1:0]  ex_valid,
  input  logic [9:0]  ex_exc_code,
  input  logic [63:0] ex_pc,
  input  logic [1:0]  ex_in_delay,
  input  logic [31:0] epc_i,
  input  logic        pipe_empty,
  input  logic        if_ready,
  output logic        commit_valid,
  output logic [4:0]  commit_code,
  output logic [31:0] commit_pc,
  output logic        commit_bd,
  output logic        flush_all,
  output logic        flush_icache,
  output logic        issue_stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        drain_timeout
);

  seq_state_t  state_q;
  seq_state_t  state_d;
  logic        latch_en;
  logic [31:0] target_d;

  logic        sel_valid;
  logic        sel_way;
  logic [4:0]  sel_code;
  logic [31:0] sel_pc;
  logic        sel_bd;

  logic [4:0]  evt_code_q;
  logic [31:0] evt_pc_q;
  logic        evt_bd_q;
  logic        evt_way_q;
  logic [31:0] redirect_pc_q;
  logic        flush_icache_q;

  // The latched way is kept for debug visibility; nothing downstream needs it.
  logic        unused_evt_way;
  assign unused_evt_way = evt_way_q;

  exc_way_prio u_prio (
    .int_pending (int_pending),
    .ex_valid    (ex_valid),
    .ex_exc_code (ex_exc_code),
    .ex_pc       (ex_pc),
    .ex_in_delay (ex_in_delay),
    .sel_valid   (sel_valid),
    .sel_way     (sel_way),
    .sel_code    (sel_code),
    .sel_pc      (sel_pc),
    .sel_bd      (sel_bd)
  );

`ifdef EXC_SEQ_DRAIN_TIMEOUT_EN
  logic [7:0] drain_cnt_q;
  logic       timeout_hit;
  logic       drain_timeout_q;
`else
  localparam int unused_drain_timeout = DRAIN_TIMEOUT;
`endif

  // Next-state and output decode; the ERET alignment check happens in COMMIT.
  always_comb begin
    state_d        = state_q;
    latch_en       = 1'b0;
    flush_all      = 1'b0;
    commit_valid   = 1'b0;
    commit_code    = 5'h0;
    commit_pc      = 32'h0;
    commit_bd      = 1'b0;
    issue_stall    = 1'b1;
    redirect_valid = 1'b0;
    target_d       = EXC_VECTOR;
`ifdef EXC_SEQ_DRAIN_TIMEOUT_EN
    timeout_hit    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        issue_stall = 1'b0;
        if (sel_valid) begin
          latch_en  = 1'b1;
          flush_all = 1'b1;
          state_d   = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        commit_valid = 1'b1;
        commit_pc    = evt_pc_q;
        commit_bd    = evt_bd_q;
        if (evt_code_q == EXC_ERET && epc_i[1:0] != 2'b00) begin
          commit_code = EXC_ADEL;
          target_d    = EXC_VECTOR;
        end else if (evt_code_q == EXC_ERET) begin
          commit_code = EXC_ERET;
          target_d    = epc_i;
        end else begin
          commit_code = evt_code_q;
          target_d    = EXC_VECTOR;
        end
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pipe_empty) begin
          state_d = ST_REDIRECT;
        end
`ifdef EXC_SEQ_DRAIN_TIMEOUT_EN
        else if (drain_cnt_q == 8'(DRAIN_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = ST_REDIRECT;
        end
`endif
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        if (if_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset drops any sequence in flight straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the picked event when IDLE accepts it; later ex_* changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_code_q <= 5'h0;
      evt_pc_q   <= 32'h0;
      evt_bd_q   <= 1'b0;
      evt_way_q  <= 1'b0;
    end else if (latch_en) begin
      evt_code_q <= sel_code;
      evt_pc_q   <= sel_pc;
      evt_bd_q   <= sel_bd;
      evt_way_q  <= sel_way;
    end
  end

  // Redirect target is frozen in COMMIT so it stays stable through the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pc_q <= 32'h0;
    end else if (state_q == ST_COMMIT) begin
      redirect_pc_q <= target_d;
    end
  end

  // I-cache flush follows the pipeline flush one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_icache_q <= 1'b0;
    end else begin
      flush_icache_q <= flush_all;
    end
  end

`ifdef EXC_SEQ_DRAIN_TIMEOUT_EN
  // Watchdog counter runs only while draining and restarts on every new drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt_q <= 8'h0;
    end else if (state_q == ST_DRAIN) begin
      drain_cnt_q <= drain_cnt_q + 8'd1;
    end else begin
      drain_cnt_q <= 8'h0;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      drain_timeout_q <= 1'b1;
    end
  end

  assign drain_timeout = drain_timeout_q;
`else
  assign drain_timeout = 1'b0;
`endif

  assign redirect_pc  = redirect_pc_q;
  assign flush_icache = flush_icache_q;

endmodule
